mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_starve_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D backing-memory port arbiter.
// State encodings stay plain localparams so older blocks can compare against them directly.
package mem_port_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Wide enough for any starvation limit in 1..15.
    localparam int STARVE_W = 4;

    function automatic int line_off_w(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of cycles a pending I request has lost arbitration.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] count_q;
    logic [STARVE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared line-wide memory port between I-fetch refill and D-cache traffic.
// One transaction in flight; D has priority unless a waiting I request has starved.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int LINE_BITS    = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 i_req_valid,
    input  logic [ADDR_W-1:0]    i_req_addr,
    output logic                 i_req_ready,
    output logic                 i_resp_valid,
    output logic [LINE_BITS-1:0] i_resp_data,

    input  logic                 d_req_valid,
    input  logic                 d_req_write,
    input  logic [ADDR_W-1:0]    d_req_addr,
    input  logic [LINE_BITS-1:0] d_req_wdata,
    output logic                 d_req_ready,
    output logic                 d_resp_valid,
    output logic [LINE_BITS-1:0] d_resp_data,

    output logic                 mem_req_valid,
    output logic                 mem_req_write,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [LINE_BITS-1:0] mem_req_wdata,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_data,

    output logic                 busy,
    output logic                 owner_d,
    output logic [31:0]          i_grant_cnt,
    output logic [31:0]          d_grant_cnt
);

    localparam int OFF_W = line_off_w(LINE_BITS);
    localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W-OFF_W){1'b0}}, {OFF_W{1'b1}}};

    state_t               state_q,    state_d;
    logic [ADDR_W-1:0]    addr_q,     addr_d;
    logic                 write_q,    write_d;
    logic [LINE_BITS-1:0] wdata_q,    wdata_d;
    logic [LINE_BITS-1:0] data_q,     data_d;
    logic                 owner_is_d_q, owner_is_d_d;
    logic [31:0]          i_grant_q,  i_grant_d;
    logic [31:0]          d_grant_q,  d_grant_d;

    logic starve_at_limit;
    logic d_win;
    logic i_win;
    logic i_accept;
    logic d_accept;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (i_req_valid && !i_accept),
        .clear    (i_accept),
        .at_limit (starve_at_limit)
    );

    // Win flags imply the matching valid, so ready alone marks an accept.
    assign d_win    = d_req_valid && !(i_req_valid && starve_at_limit);
    assign i_win    = !d_win && i_req_valid;
    assign d_accept = (state_q == ST_IDLE) && d_win;
    assign i_accept = (state_q == ST_IDLE) && i_win;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        owner_is_d_d = owner_is_d_q;
        i_grant_d    = i_grant_q + {31'b0, i_accept};
        d_grant_d    = d_grant_q + {31'b0, d_accept};

        case (state_q)
            ST_IDLE: begin
                if (d_accept || i_accept) begin
                    state_d      = ST_ISSUE;
                    owner_is_d_d = d_accept;
                    addr_d       = (d_accept ? d_req_addr : i_req_addr) & ~OFF_MASK;
                    write_d      = d_accept && d_req_write;
                    wdata_d      = d_accept ? d_req_wdata : '0;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = write_q ? '0 : mem_resp_data;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            data_q       <= '0;
            owner_is_d_q <= 1'b0;
            i_grant_q    <= '0;
            d_grant_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            owner_is_d_q <= owner_is_d_d;
            i_grant_q    <= i_grant_d;
            d_grant_q    <= d_grant_d;
        end
    end

    assign i_req_ready   = i_accept;
    assign d_req_ready   = d_accept;

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_write = write_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;

    assign i_resp_valid  = (state_q == ST_RESP) && !owner_is_d_q;
    assign d_resp_valid  = (state_q == ST_RESP) &&  owner_is_d_q;
    assign i_resp_data   = i_resp_valid ? data_q : '0;
    assign d_resp_data   = d_resp_valid ? data_q : '0;

    assign busy          = (state_q != ST_IDLE);
    assign owner_d       = owner_is_d_q;
    assign i_grant_cnt   = i_grant_q;
    assign d_grant_cnt   = d_grant_q;

endmodule
